iomem_arbiter: RTL and testbench

//  Two-master arbiter driving the single external iomem port (128-bit line, 16 byte-lane rw mask).

---
 rtl/iomem_arbiter.sv | 141 ++++++++++++++
 tb/tb_iomem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// Two-master arbiter for the single external iomem port.
// Master 0 is the icache line fill, master 1 the dcache fill/writeback.
// Only one transaction is in flight at a time. Grants are round-robin.
// Request and response paths are registered. A watchdog ends a stalled
// transaction with an error response.
//
// Handshake: a master raises m_req_valid_i and holds it until its bit of
// m_res_valid_o pulses for one cycle. The arbiter starts a transaction only
// when mem_res_ready_i is high. It then holds mem_req_valid_o and the
// request fields stable until mem_res_valid_i pulses or the watchdog expires.
module iomem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   m_req_valid_i,
  input  logic [1:0][ADDR_W-1:0]       m_req_addr_i,
  input  logic [1:0][DATA_W-1:0]       m_req_data_i,
  input  logic [1:0][DATA_W/8-1:0]     m_req_rw_i,
  output logic [1:0]                   m_res_valid_o,
  output logic                         m_res_err_o,
  output logic [DATA_W-1:0]            m_res_data_o,
  output logic                         mem_req_valid_o,
  output logic [ADDR_W-1:0]            mem_req_addr_o,
  output logic [DATA_W-1:0]            mem_req_data_o,
  output logic [DATA_W/8-1:0]          mem_req_rw_o,
  input  logic                         mem_res_valid_i,
  input  logic                         mem_res_ready_i,
  input  logic [DATA_W-1:0]            mem_res_data_i,
  output logic [1:0]                   dbg_state_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                grant_q;
  logic                last_grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_req_valid_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic [MASK_W-1:0]   req_rw_q;
  logic [1:0]          res_valid_q;
  logic                res_err_q;
  logic [DATA_W-1:0]   res_data_q;

  logic                gnt_d;
  logic                take_req;
  logic                timeout_hit;

  // Round-robin pick: the only requester wins, a tie goes away from the last grant.
  always_comb begin
    gnt_d = 1'b0;
    if (m_req_valid_i == 2'b11) begin
      gnt_d = ~last_grant_q;
    end else begin
      gnt_d = m_req_valid_i[1];
    end
  end

  assign take_req    = mem_res_ready_i && (|m_req_valid_i);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_rw_q        <= '0;
      res_valid_q     <= 2'b00;
      res_err_q       <= 1'b0;
      res_data_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take_req) begin
            grant_q         <= gnt_d;
            req_addr_q      <= m_req_addr_i[gnt_d];
            req_data_q      <= m_req_data_i[gnt_d];
            req_rw_q        <= m_req_rw_i[gnt_d];
            mem_req_valid_q <= 1'b1;
            cnt_q           <= '0;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the same cycle as the timeout still wins.
          if (mem_res_valid_i) begin
            res_data_q      <= mem_res_data_i;
            res_err_q       <= 1'b0;
            res_valid_q     <= grant_q ? 2'b10 : 2'b01;
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RESP;
          end else if (timeout_hit) begin
            res_data_q      <= '0;
            res_err_q       <= 1'b1;
            res_valid_q     <= grant_q ? 2'b10 : 2'b01;
            mem_req_valid_q <= 1'b0;
            state_q         <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          // The strobe lasts one cycle; data and err keep their values.
          res_valid_q  <= 2'b00;
          last_grant_q <= grant_q;
          cnt_q        <= '0;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_res_valid_o   = res_valid_q;
  assign m_res_err_o     = res_err_q;
  assign m_res_data_o    = res_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_data_o  = req_data_q;
  assign mem_req_rw_o    = req_rw_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter. The watchdog is shortened to 16 cycles.
// The bench drives inputs 1ns after a rising edge.
// It samples the registered outputs at the same point.
module tb_iomem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int TO_CYC = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [1:0]               m_req_valid;
  logic [1:0][ADDR_W-1:0]   m_req_addr;
  logic [1:0][DATA_W-1:0]   m_req_data;
  logic [1:0][MASK_W-1:0]   m_req_rw;
  logic [1:0]               m_res_valid;
  logic                     m_res_err;
  logic [DATA_W-1:0]        m_res_data;
  logic                     mem_req_valid;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [DATA_W-1:0]        mem_req_data;
  logic [MASK_W-1:0]        mem_req_rw;
  logic                     mem_res_valid;
  logic                     mem_res_ready;
  logic [DATA_W-1:0]        mem_res_data;
  logic [1:0]               dbg_state;

  iomem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .m_req_valid_i   (m_req_valid),
    .m_req_addr_i    (m_req_addr),
    .m_req_data_i    (m_req_data),
    .m_req_rw_i      (m_req_rw),
    .m_res_valid_o   (m_res_valid),
    .m_res_err_o     (m_res_err),
    .m_res_data_o    (m_res_data),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_data_o  (mem_req_data),
    .mem_req_rw_o    (mem_req_rw),
    .mem_res_valid_i (mem_res_valid),
    .mem_res_ready_i (mem_res_ready),
    .mem_res_data_i  (mem_res_data),
    .dbg_state_o     (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE with the current master inputs.
  // The memory answers `lat` cycles after the grant edge.
  // On return the arbiter is in RESP with the strobe visible.
  task automatic serve(input string tag, input int lat, input logic [127:0] rdata,
                       input logic [1:0] exp_strb, input logic [31:0] exp_addr,
                       input logic [127:0] exp_wdata, input logic [15:0] exp_rw,
                       input bit perturb, input bit chk_rdata);
    tick();
    check({tag, "_reqv"}, mem_req_valid, 1);
    check({tag, "_addr"}, mem_req_addr, exp_addr);
    check({tag, "_rw"}, mem_req_rw, exp_rw);
    check({tag, "_wdata"}, mem_req_data, exp_wdata);
    if (perturb) begin
      m_req_addr[0] = m_req_addr[0] ^ 32'hFFFF_0000;
      m_req_addr[1] = m_req_addr[1] ^ 32'hFFFF_0000;
      m_req_data[0] = ~m_req_data[0];
      m_req_data[1] = ~m_req_data[1];
      m_req_rw[0]   = ~m_req_rw[0];
      m_req_rw[1]   = ~m_req_rw[1];
    end
    for (int i = 1; i < lat; i++) begin
      tick();
      check({tag, "_wait_reqv"}, mem_req_valid, 1);
      check({tag, "_wait_addr"}, mem_req_addr, exp_addr);
      check({tag, "_wait_rw"}, mem_req_rw, exp_rw);
      check({tag, "_wait_wdata"}, mem_req_data, exp_wdata);
      check({tag, "_wait_nostrb"}, m_res_valid, 2'b00);
    end
    mem_res_valid = 1'b1;
    mem_res_data  = rdata;
    tick();
    mem_res_valid = 1'b0;
    check({tag, "_strb"}, m_res_valid, exp_strb);
    check({tag, "_err"}, m_res_err, 0);
    check({tag, "_reqv_drop"}, mem_req_valid, 0);
    check({tag, "_st_resp"}, dbg_state, ST_RESP);
    if (chk_rdata) check({tag, "_rdata"}, m_res_data, rdata);
  endtask

  // Master drops its request on seeing the strobe; arbiter returns to IDLE.
  task automatic finish_resp(input string tag);
    m_req_valid = 2'b00;
    tick();
    check({tag, "_strb_off"}, m_res_valid, 2'b00);
    check({tag, "_st_idle"}, dbg_state, ST_IDLE);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] D_BEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
  localparam logic [127:0] D_WR   = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

  initial begin
    rst_n         = 1'b0;
    m_req_valid   = 2'b00;
    m_req_addr    = '0;
    m_req_data    = '0;
    m_req_rw      = '0;
    mem_res_valid = 1'b0;
    mem_res_ready = 1'b1;
    mem_res_data  = '0;

    // reset state
    do_reset();
    check("rst_reqv", mem_req_valid, 0);
    check("rst_strb", m_res_valid, 2'b00);
    check("rst_err", m_res_err, 0);
    check("rst_rdata", m_res_data, 0);
    check("rst_addr", mem_req_addr, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // 1: master 0 read, memory answers 8 cycles after the grant
    m_req_addr[0] = 32'h0000_0040;
    m_req_valid   = 2'b01;
    check("t1_reqv_pre", mem_req_valid, 0);
    serve("t1", 8, D_BEEF, 2'b01, 32'h0000_0040, 128'h0, 16'h0000, 1'b0, 1'b1);
    finish_resp("t1");

    // 2: both masters held after reset; grants alternate 0,1,0,1
    do_reset();
    m_req_addr[0] = 32'h0000_0200;
    m_req_addr[1] = 32'h0000_0300;
    m_req_valid   = 2'b11;
    serve("t2a", 2, 128'hA0, 2'b01, 32'h200, 128'h0, 16'h0, 1'b0, 1'b1);
    tick();
    check("t2a_idle_reqv", mem_req_valid, 0);
    serve("t2b", 2, 128'hB1, 2'b10, 32'h300, 128'h0, 16'h0, 1'b0, 1'b1);
    tick();
    serve("t2c", 3, 128'hC2, 2'b01, 32'h200, 128'h0, 16'h0, 1'b0, 1'b1);
    tick();
    serve("t2d", 1, 128'hD3, 2'b10, 32'h300, 128'h0, 16'h0, 1'b0, 1'b1);
    finish_resp("t2");

    // 3: master 1 byte-masked write; request fields stay put even if inputs move
    m_req_addr[1] = 32'h0000_0100;
    m_req_data[1] = D_WR;
    m_req_rw[1]   = 16'h00F0;
    m_req_valid   = 2'b10;
    serve("t3", 5, 128'h0, 2'b10, 32'h100, D_WR, 16'h00F0, 1'b1, 1'b0);
    finish_resp("t3");
    m_req_rw   = '0;
    m_req_data = '0;

    // 4: memory not ready for 5 cycles, then master 0 is granted
    m_req_addr[0] = 32'h0000_0400;
    m_req_valid   = 2'b01;
    mem_res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_noreq", mem_req_valid, 0);
      check("t4_idle", dbg_state, ST_IDLE);
    end
    mem_res_ready = 1'b1;
    serve("t4", 3, 128'h44, 2'b01, 32'h400, 128'h0, 16'h0, 1'b0, 1'b1);
    finish_resp("t4");

    // 7: response in the same cycle as the timeout wins with err=0
    m_req_addr[1] = 32'h0000_0700;
    m_req_valid   = 2'b10;
    serve("t7", TO_CYC, 128'h7777, 2'b10, 32'h700, 128'h0, 16'h0, 1'b0, 1'b1);
    finish_resp("t7");

    // 5: no memory response -> error strobe 16 cycles after the grant
    m_req_addr[0] = 32'h0000_0500;
    m_req_valid   = 2'b01;
    tick();
    check("t5_reqv", mem_req_valid, 1);
    for (int i = 1; i < TO_CYC; i++) begin
      tick();
      check("t5_wait_reqv", mem_req_valid, 1);
      check("t5_wait_nostrb", m_res_valid, 2'b00);
    end
    tick();
    check("t5_strb", m_res_valid, 2'b01);
    check("t5_err", m_res_err, 1);
    check("t5_rdata_zero", m_res_data, 0);
    check("t5_reqv_drop", mem_req_valid, 0);
    m_req_valid = 2'b00;
    tick();
    check("t5_strb_off", m_res_valid, 2'b00);
    check("t5_err_held", m_res_err, 1);
    check("t5_reqv_low", mem_req_valid, 0);
    m_req_valid = 2'b01;
    serve("t5n", 3, 128'h5555, 2'b01, 32'h500, 128'h0, 16'h0, 1'b0, 1'b1);
    finish_resp("t5n");

    // 6: reset during WAIT drops the transaction; last_grant returns to 1
    m_req_addr[1] = 32'h0000_0600;
    m_req_valid   = 2'b10;
    tick();
    check("t6_reqv", mem_req_valid, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_reqv", mem_req_valid, 0);
    check("t6_rst_strb", m_res_valid, 2'b00);
    check("t6_rst_err", m_res_err, 0);
    check("t6_rst_rdata", m_res_data, 0);
    check("t6_rst_addr", mem_req_addr, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    m_req_valid   = 2'b00;
    mem_res_valid = 1'b1;
    mem_res_data  = 128'hBAD;
    tick();
    mem_res_valid = 1'b0;
    check("t6_ign_strb", m_res_valid, 2'b00);
    check("t6_ign_reqv", mem_req_valid, 0);
    check("t6_ign_rdata", m_res_data, 0);
    m_req_addr[0] = 32'h0000_0660;
    m_req_valid   = 2'b11;
    serve("t6n", 2, 128'h66, 2'b01, 32'h660, 128'h0, 16'h0, 1'b0, 1'b1);
    finish_resp("t6n");

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
